// File: rtl/hash_table_cmd_master_if.sv
// Command/response stream between the hash table command master and axi_wrapper.
// The master modport is the initiator side; the slave modport is the axi_wrapper side.
interface hash_table_cmd_master_if;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [31:0] res_data_i;
  logic        res_valid_i;
  logic        res_ready_o;

  modport master (
    output cmd_data_o, cmd_valid_o, res_ready_o,
    input  cmd_ready_i, res_data_i, res_valid_i
  );

  modport slave (
    input  cmd_data_o, cmd_valid_o, res_ready_o,
    output cmd_ready_i, res_data_i, res_valid_i
  );
endinterface

// File: rtl/hash_table_cmd_master.sv
// Packs host requests into 32-bit hash table commands and returns the in-order
// responses to the host, tagged with the key of the command each one answers.
module hash_table_cmd_master #(
  parameter int KEY_WIDTH       = 4,
  parameter int DATA_WIDTH      = 26,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [1:0]                           req_op,
  input  logic [KEY_WIDTH-1:0]                 req_key,
  input  logic [DATA_WIDTH-1:0]                req_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic                                 rsp_found,
  output logic                                 rsp_is_write,
  output logic [KEY_WIDTH-1:0]                 rsp_key,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic [7:0]                           illegal_cnt,
  output logic                                 orphan_err,
  hash_table_cmd_master_if.master              bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BAD   = 2'b11
  } op_e;

  logic [31:0]          cmd_data_q;
  logic                 cmd_valid_q;
  logic                 req_accept;
  logic                 req_legal;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 res_ready;
  logic                 res_fire;
  logic [KEY_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  assign req_ready  = (!cmd_valid_q || bus.cmd_ready_i) && (outstanding < MAX_CNT);
  assign req_accept = req_valid && req_ready;
  assign req_legal  = (op_e'(req_op) == OP_WRITE) || (op_e'(req_op) == OP_READ);
  assign tag_push   = req_accept && req_legal;
  assign res_ready  = !rsp_valid || rsp_ready;
  assign res_fire   = bus.res_valid_i && res_ready;
  assign tag_pop    = res_fire && (outstanding != '0);

  assign bus.cmd_data_o  = cmd_data_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.res_ready_o = res_ready;

  // The command register is only reloaded once the previous word has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
    end else if (tag_push) begin
      cmd_valid_q <= 1'b1;
      cmd_data_q  <= {req_op, req_key, req_data};
    end else if (bus.cmd_ready_i) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // Tag FIFO occupancy always equals outstanding, so the count doubles as the fill level.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[wr_ptr] <= req_key;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (tag_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tag_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({tag_push, tag_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (req_accept && !req_legal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  // A response with nothing outstanding is swallowed and only flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_found    <= 1'b0;
      rsp_is_write <= 1'b0;
      rsp_key      <= '0;
      rsp_data     <= '0;
      orphan_err   <= 1'b0;
    end else begin
      if (tag_pop) begin
        rsp_valid    <= 1'b1;
        rsp_found    <= bus.res_data_i[31];
        rsp_is_write <= bus.res_data_i[30];
        rsp_key      <= tag_mem[rd_ptr];
        rsp_data     <= bus.res_data_i[DATA_WIDTH-1:0];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (res_fire && (outstanding == '0)) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hash_table_cmd_master.sv
// Directed and randomized checks of hash_table_cmd_master against a queue-based
// transaction model of the host, command and response streams.
module tb_hash_table_cmd_master;

  localparam int KW = 4;
  localparam int DW = 26;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [KW-1:0] req_key;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_found;
  logic          rsp_is_write;
  logic [KW-1:0] rsp_key;
  logic [DW-1:0] rsp_data;
  logic [2:0]    outstanding;
  logic [7:0]    illegal_cnt;
  logic          orphan_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [KW-1:0] key;
    logic [31:0]   word;
  } rsp_t;

  logic [31:0]   cmd_q[$];
  logic [31:0]   slave_q[$];
  logic [KW-1:0] key_q[$];
  rsp_t          rsp_q[$];
  int            ill_model;

  hash_table_cmd_master_if bus();

  hash_table_cmd_master #(
    .KEY_WIDTH(KW),
    .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_key(req_key),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_found(rsp_found),
    .rsp_is_write(rsp_is_write),
    .rsp_key(rsp_key),
    .rsp_data(rsp_data),
    .outstanding(outstanding),
    .illegal_cnt(illegal_cnt),
    .orphan_err(orphan_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [KW-1:0] key,
                               input logic [DW-1:0] data);
    req_valid = v;
    req_op    = op;
    req_key   = key;
    req_data  = data;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 2'b00, '0, '0);
    bus.cmd_ready_i = 1'b1;
    bus.res_valid_i = 1'b0;
    bus.res_data_i  = '0;
    rsp_ready       = 1'b1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic respond(input logic [31:0] word);
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = word;
    tick();
    bus.res_valid_i = 1'b0;
  endtask

  // One cycle of random traffic; the model tracks transactions, not DUT registers.
  task automatic randomCycle(input bit drain);
    bit            acc, cmd_hs, res_hs, rsp_hs, legal;
    logic [31:0]   w;
    logic [KW-1:0] k;
    rsp_t          e;
    int            r;
    r = $urandom_range(0, 9);
    legal = (r >= 2);
    applyStimulus(drain ? 1'b0 : 1'($urandom),
                  (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01,
                  KW'($urandom), DW'($urandom));
    bus.cmd_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    rsp_ready       = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    bus.res_valid_i = (slave_q.size() > 0) && (drain || 1'($urandom));
    bus.res_data_i  = bus.res_valid_i ? slave_q[0] : $urandom;
    #1;
    checkOutput("rand_outstanding", 32'(outstanding), 32'(key_q.size()));
    acc    = req_valid && req_ready;
    cmd_hs = bus.cmd_valid_o && bus.cmd_ready_i;
    res_hs = bus.res_valid_i && bus.res_ready_o;
    rsp_hs = rsp_valid && rsp_ready;
    if (rsp_hs) begin
      if (rsp_q.size() == 0) begin
        checkOutput("rand_unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        e = rsp_q.pop_front();
        checkOutput("rand_rsp_key", 32'(rsp_key), 32'(e.key));
        checkOutput("rand_rsp_found", 32'(rsp_found), 32'(e.word[31]));
        checkOutput("rand_rsp_is_write", 32'(rsp_is_write), 32'(e.word[30]));
        checkOutput("rand_rsp_data", 32'(rsp_data), 32'(e.word[25:0]));
      end
    end
    if (cmd_hs) begin
      if (cmd_q.size() == 0) begin
        checkOutput("rand_unexpected_cmd", 32'(bus.cmd_valid_o), 32'(0));
      end else begin
        w = cmd_q.pop_front();
        checkOutput("rand_cmd_data", bus.cmd_data_o, w);
        slave_q.push_back({1'($urandom), (w[31:30] == 2'b10), 4'($urandom), 26'($urandom)});
      end
    end
    if (res_hs) begin
      w = slave_q.pop_front();
      k = key_q.pop_front();
      rsp_q.push_back('{key: k, word: w});
    end
    if (acc) begin
      if (legal) begin
        cmd_q.push_back({req_op, req_key, req_data});
        key_q.push_back(req_key);
      end else if (ill_model < 255) begin
        ill_model++;
      end
    end
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idleInputs();
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_cmd_valid", 32'(bus.cmd_valid_o), 32'(0));
    checkOutput("rst_cmd_data", bus.cmd_data_o, 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_key", 32'(rsp_key), 32'(0));
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'(0));
    checkOutput("rst_outstanding", 32'(outstanding), 32'(0));
    checkOutput("rst_illegal", 32'(illegal_cnt), 32'(0));
    checkOutput("rst_orphan", 32'(orphan_err), 32'(0));
    reset = 1'b0;

    $display("[TB] write key 6 data 2");
    applyStimulus(1'b1, 2'b10, 4'd6, 26'd2);
    #1;
    checkOutput("wr_req_ready", 32'(req_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("wr_cmd_valid", 32'(bus.cmd_valid_o), 32'(1));
    checkOutput("wr_cmd_data", bus.cmd_data_o, 32'h98000002);
    checkOutput("wr_outstanding", 32'(outstanding), 32'(1));
    tick();
    checkOutput("wr_cmd_valid_one_cycle", 32'(bus.cmd_valid_o), 32'(0));
    respond(32'hC0000000);
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'(1));
    checkOutput("wr_rsp_is_write", 32'(rsp_is_write), 32'(1));
    checkOutput("wr_rsp_found", 32'(rsp_found), 32'(1));
    checkOutput("wr_rsp_key", 32'(rsp_key), 32'h6);
    checkOutput("wr_rsp_outstanding", 32'(outstanding), 32'(0));
    tick();
    checkOutput("wr_rsp_valid_clear", 32'(rsp_valid), 32'(0));

    $display("[TB] read key 6");
    applyStimulus(1'b1, 2'b01, 4'd6, 26'd0);
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("rd_cmd_data", bus.cmd_data_o, 32'h58000000);
    checkOutput("rd_outstanding", 32'(outstanding), 32'(1));
    tick();
    respond(32'h80000002);
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'(1));
    checkOutput("rd_rsp_found", 32'(rsp_found), 32'(1));
    checkOutput("rd_rsp_is_write", 32'(rsp_is_write), 32'(0));
    checkOutput("rd_rsp_key", 32'(rsp_key), 32'h6);
    checkOutput("rd_rsp_data", 32'(rsp_data), 32'h2);
    checkOutput("rd_outstanding_0", 32'(outstanding), 32'(0));
    tick();

    $display("[TB] command stall");
    bus.cmd_ready_i = 1'b0;
    applyStimulus(1'b1, 2'b10, 4'hD, 26'd4);
    tick();
    applyStimulus(1'b1, 2'b01, 4'h1, 26'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_req_ready", 32'(req_ready), 32'(0));
      checkOutput("stall_cmd_data", bus.cmd_data_o, 32'hB4000004);
      checkOutput("stall_cmd_valid", 32'(bus.cmd_valid_o), 32'(1));
      tick();
    end
    bus.cmd_ready_i = 1'b1;
    #1;
    checkOutput("stall_release_ready", 32'(req_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("stall_next_cmd", bus.cmd_data_o, 32'h44000000);
    checkOutput("stall_outstanding", 32'(outstanding), 32'(2));
    tick();
    respond(32'hC0000000);
    checkOutput("stall_rsp1_key", 32'(rsp_key), 32'hD);
    checkOutput("stall_rsp1_is_write", 32'(rsp_is_write), 32'(1));
    respond(32'h00000000);
    checkOutput("stall_rsp2_key", 32'(rsp_key), 32'h1);
    checkOutput("stall_rsp2_found", 32'(rsp_found), 32'(0));
    checkOutput("stall_outstanding_0", 32'(outstanding), 32'(0));
    tick();

    $display("[TB] outstanding limit");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 2'b01, KW'(i), 26'd0);
      tick();
    end
    applyStimulus(1'b1, 2'b01, 4'd5, 26'd0);
    #1;
    checkOutput("lim_req_ready", 32'(req_ready), 32'(0));
    checkOutput("lim_outstanding", 32'(outstanding), 32'(4));
    tick();
    checkOutput("lim_cmd_valid_idle", 32'(bus.cmd_valid_o), 32'(0));
    respond(32'h80000011);
    checkOutput("lim_rsp_key1", 32'(rsp_key), 32'h1);
    checkOutput("lim_outstanding_3", 32'(outstanding), 32'(3));
    #1;
    checkOutput("lim_req_ready_again", 32'(req_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("lim_fifth_cmd", bus.cmd_data_o, 32'h54000000);
    checkOutput("lim_fifth_valid", 32'(bus.cmd_valid_o), 32'(1));
    checkOutput("lim_outstanding_4", 32'(outstanding), 32'(4));
    for (int k = 2; k <= 5; k++) begin
      respond(32'(k));
      checkOutput("lim_drain_key", 32'(rsp_key), 32'(k));
      checkOutput("lim_drain_data", 32'(rsp_data), 32'(k));
    end
    checkOutput("lim_outstanding_end", 32'(outstanding), 32'(0));
    tick();

    $display("[TB] illegal requests");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 4'd3, 26'd9);
      tick();
    end
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("ill_no_cmd", 32'(bus.cmd_valid_o), 32'(0));
    checkOutput("ill_cnt3", 32'(illegal_cnt), 32'(3));
    checkOutput("ill_outstanding", 32'(outstanding), 32'(0));
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, KW'(i), DW'(i));
      tick();
    end
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("ill_cnt_sat", 32'(illegal_cnt), 32'(255));
    checkOutput("ill_sat_no_cmd", 32'(bus.cmd_valid_o), 32'(0));

    $display("[TB] orphan response");
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = 32'hC0000001;
    #1;
    checkOutput("orph_res_ready", 32'(bus.res_ready_o), 32'(1));
    tick();
    bus.res_valid_i = 1'b0;
    checkOutput("orph_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("orph_err", 32'(orphan_err), 32'(1));
    tick();
    tick();
    tick();
    checkOutput("orph_err_sticky", 32'(orphan_err), 32'(1));
    doReset();
    checkOutput("orph_err_reset", 32'(orphan_err), 32'(0));
    checkOutput("ill_cnt_reset", 32'(illegal_cnt), 32'(0));

    $display("[TB] reset mid-operation");
    bus.cmd_ready_i = 1'b0;
    applyStimulus(1'b1, 2'b01, 4'd7, 26'd0);
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0);
    checkOutput("mid_cmd_valid", 32'(bus.cmd_valid_o), 32'(1));
    checkOutput("mid_outstanding", 32'(outstanding), 32'(1));
    doReset();
    checkOutput("mid_cmd_dropped", 32'(bus.cmd_valid_o), 32'(0));
    checkOutput("mid_outstanding_0", 32'(outstanding), 32'(0));
    respond(32'h80000007);
    checkOutput("mid_late_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("mid_late_orphan", 32'(orphan_err), 32'(1));
    doReset();

    $display("[TB] randomized traffic");
    ill_model = 0;
    for (int i = 0; i < 2000; i++) begin
      randomCycle(1'b0);
    end
    n = 0;
    while ((cmd_q.size() + slave_q.size() + key_q.size() + rsp_q.size() != 0) && (n < 200)) begin
      randomCycle(1'b1);
      n++;
    end
    checkOutput("rand_drain_done", 32'(cmd_q.size() + slave_q.size() + key_q.size() + rsp_q.size()), 32'(0));
    checkOutput("rand_illegal_cnt", 32'(illegal_cnt), 32'(ill_model));
    checkOutput("rand_no_orphan", 32'(orphan_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
